// File: rtl/seven_seg_scan_ctrl_if.sv
// Bus bundle for the 7-segment scan controller: load/ack handshake,
// the value inputs and the display drive outputs.
interface seven_seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    ack;
  logic                    frame_tick;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;

  modport master (
    output load, value, dp_in, digit_en,
    input  ack, frame_tick, an, seg, dp
  );

  modport slave (
    input  load, value, dp_in, digit_en,
    output ack, frame_tick, an, seg, dp
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scanner with a shadow display value
// that is only updated at frame boundaries via a load/ack handshake.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seven_seg_scan_ctrl_if.slave  bus
);
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW    = 4 * NUM_DIGITS;

  typedef enum logic {PH_BLANK, PH_DRIVE} phase_e;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VW-1:0]         shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [VW-1:0]         pend_q, pend_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  ack_q, ack_d;
  logic                  tick_q, tick_d;

  logic                  cnt_wrap, idx_last, boundary;
  logic [VW-1:0]         shifted;
  logic [3:0]            nib;
  phase_e                phase;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;  default: decode = 7'h0E;
    endcase
  endfunction

  always_comb begin
    cnt_wrap = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    idx_last = (idx_q == IDX_W'(NUM_DIGITS - 1));
    boundary = cnt_wrap && idx_last;
    phase    = (int'(cnt_q) < BLANK_CYCLES) ? PH_BLANK : PH_DRIVE;
    shifted  = shadow_q >> {idx_q, 2'b00};
    nib      = shifted[3:0];
  end

  always_comb begin
    cnt_d       = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    pend_d      = pend_q;
    pend_dp_d   = pend_dp_q;
    pend_vld_d  = pend_vld_q;
    an_d        = '1;
    seg_d       = 7'h7F;
    dp_d        = 1'b1;
    ack_d       = boundary && (pend_vld_q || bus.load);
    tick_d      = boundary;

    if (cnt_wrap) begin
      idx_d = idx_last ? '0 : idx_q + 1'b1;
    end

    // A load on the boundary cycle bypasses the pending regs and wins over them.
    if (boundary) begin
      if (bus.load) begin
        shadow_d    = bus.value;
        shadow_dp_d = bus.dp_in;
      end else if (pend_vld_q) begin
        shadow_d    = pend_q;
        shadow_dp_d = pend_dp_q;
      end
      pend_vld_d = 1'b0;
    end else if (bus.load) begin
      pend_d     = bus.value;
      pend_dp_d  = bus.dp_in;
      pend_vld_d = 1'b1;
    end

    if (phase == PH_DRIVE && bus.digit_en[idx_q]) begin
      an_d[idx_q] = 1'b0;
      seg_d       = decode(nib);
      dp_d        = ~shadow_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      pend_q      <= '0;
      pend_dp_q   <= '0;
      pend_vld_q  <= 1'b0;
      an_q        <= '1;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
      ack_q       <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      pend_q      <= pend_d;
      pend_dp_q   <= pend_dp_d;
      pend_vld_q  <= pend_vld_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      ack_q       <= ack_d;
      tick_q      <= tick_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.ack        = ack_q;
  assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomized self-checking bench for seven_seg_scan_ctrl against a
// time-indexed reference model of the scan and handshake.
module tb_seven_seg_scan_ctrl;
  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Reference model: time since reset release plus displayed/pending values.
  int          t;
  logic [15:0] sh_m;
  logic [3:0]  sdp_m;
  logic        pend_m;
  logic [15:0] pv_m;
  logic [3:0]  pdp_m;
  logic [6:0]  dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0; sh_m = '0; sdp_m = '0; pend_m = 1'b0; pv_m = '0; pdp_m = '0;
  endtask

  function automatic bit boundary_next();
    return ((t % RD) == RD - 1) && (((t / RD) % ND) == ND - 1);
  endfunction

  task automatic cycle();
    int         cnt, idx;
    bit         bnd, drv;
    logic [3:0] e_an, nib;
    logic [6:0] e_seg;
    logic       e_dp, e_ack, e_tick;
    @(posedge clk);
    cnt    = t % RD;
    idx    = (t / RD) % ND;
    bnd    = (cnt == RD - 1) && (idx == ND - 1);
    drv    = (cnt >= BC) && bus.digit_en[idx];
    e_an   = 4'hF;
    e_seg  = 7'h7F;
    e_dp   = 1'b1;
    if (drv) begin
      nib       = 4'(sh_m >> (4 * idx));
      e_an[idx] = 1'b0;
      e_seg     = dec[nib];
      e_dp      = ~sdp_m[idx];
    end
    e_ack  = bnd && (pend_m || bus.load);
    e_tick = bnd;
    if (bnd) begin
      if (bus.load) begin
        sh_m = bus.value; sdp_m = bus.dp_in;
      end else if (pend_m) begin
        sh_m = pv_m; sdp_m = pdp_m;
      end
      pend_m = 1'b0;
    end else if (bus.load) begin
      pend_m = 1'b1; pv_m = bus.value; pdp_m = bus.dp_in;
    end
    t++;
    #1;
    chk("an",   32'(bus.an),         32'(e_an));
    chk("seg",  32'(bus.seg),        32'(e_seg));
    chk("dp",   32'(bus.dp),         32'(e_dp));
    chk("ack",  32'(bus.ack),        32'(e_ack));
    chk("tick", 32'(bus.frame_tick), 32'(e_tick));
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.load = 1'b0;
      cycle();
    end
  endtask

  task automatic load_now(input logic [15:0] v, input logic [3:0] d);
    bus.load = 1'b1; bus.value = v; bus.dp_in = d;
    cycle();
    bus.load = 1'b0;
  endtask

  task automatic reset_check();
    #1;
    chk("rst_an",   32'(bus.an),         32'hF);
    chk("rst_seg",  32'(bus.seg),        32'h7F);
    chk("rst_dp",   32'(bus.dp),         32'h1);
    chk("rst_ack",  32'(bus.ack),        32'h0);
    chk("rst_tick", 32'(bus.frame_tick), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.load = 1'b0; bus.value = '0; bus.dp_in = '0; bus.digit_en = 4'hF;
    model_reset();
    @(negedge clk);
    reset_check();
    @(negedge clk);
    rst_n = 1'b1;

    idle(40);
    while ((t % (RD * ND)) != 10) idle(1);
    load_now(16'h12AF, 4'b0100);
    idle(60);

    load_now(16'h1111, 4'b0001);
    idle(3);
    load_now(16'h2222, 4'b0010);
    idle(40);

    while (!boundary_next()) idle(1);
    load_now(16'hBEEF, 4'b1001);
    idle(40);

    bus.digit_en = 4'b1010;
    idle(64);
    bus.digit_en = 4'hF;

    for (int i = 0; i < 1500; i++) begin
      bus.load = ($urandom_range(0, 39) == 0) ||
                 (boundary_next() && ($urandom_range(0, 2) == 0));
      bus.value = 16'($urandom);
      bus.dp_in = 4'($urandom);
      if ($urandom_range(0, 49) == 0) bus.digit_en = 4'($urandom);
      cycle();
    end
    bus.load = 1'b0;
    bus.digit_en = 4'hF;

    while ((t % RD) != 4) idle(1);
    load_now(16'h7C3D, 4'b1111);
    idle(2);
    #3 rst_n = 1'b0;
    reset_check();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
